// File: rtl/ram_sweep_ctrl.sv
// rtl/ram_sweep_ctrl.sv - single-port data memory with registered read and clear sweeper
module ram_sweep_ctrl #(
    parameter int          DATA_W  = 4,
    parameter int          ADDR_W  = 4,
    parameter int unsigned CLR_VAL = 0
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Clr,
    input  logic              Wr,
    input  logic              Rd_En,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Wr_D,
    output logic [DATA_W-1:0] Rd_D,
    output logic              Rd_Vld,
    output logic              Busy,
    output logic              Err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] CLR_WORD = DATA_W'(CLR_VAL);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   rd_d_q, rd_d_d;
    logic                rd_vld_q, rd_vld_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    // Next-state, array write port and output strobes
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d_d    = rd_d_q;
        rd_vld_d  = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = Addr;
        mem_wdata = Wr_D;
        case (state_q)
            ST_CLEAR: begin
                // One word per cycle; accesses are dropped and flagged
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = CLR_WORD;
                cnt_d     = cnt_q + 1'b1;
                err_d     = Wr | Rd_En;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (Clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    err_d   = Wr | Rd_En;
                end else begin
                    mem_we = Wr;
                    if (Rd_En) begin
                        rd_vld_d = 1'b1;
                        // Shared address: a simultaneous write wins the read
                        rd_d_d   = Wr ? Wr_D : mem_q[Addr];
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // Control and output registers
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q  <= ST_CLEAR;
            cnt_q    <= '0;
            rd_d_q   <= '0;
            rd_vld_q <= 1'b0;
            busy_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_d_q   <= rd_d_d;
            rd_vld_q <= rd_vld_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    // Storage array; never written on a reset edge
    always_ff @(posedge Clk) begin
        if (Rst_n && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign Rd_D   = rd_d_q;
    assign Rd_Vld = rd_vld_q;
    assign Busy   = busy_q;
    assign Err    = err_q;

endmodule

// File: tb/tb_ram_sweep_ctrl.sv
// tb/tb_ram_sweep_ctrl.sv - directed self-checking bench for ram_sweep_ctrl
module tb_ram_sweep_ctrl;

    logic       clk;
    logic       rst_n, clr, wr, rd_en;
    logic [3:0] addr, wr_d, rd_d;
    logic       rd_vld, busy, err;

    logic       p_rst_n, p_clr, p_wr, p_rd_en;
    logic [5:0] p_addr;
    logic [7:0] p_wr_d, p_rd_d;
    logic       p_rd_vld, p_busy, p_err;

    int errors = 0;
    int checks = 0;

    ram_sweep_ctrl dut (
        .Clk(clk), .Rst_n(rst_n), .Clr(clr), .Wr(wr), .Rd_En(rd_en),
        .Addr(addr), .Wr_D(wr_d), .Rd_D(rd_d), .Rd_Vld(rd_vld),
        .Busy(busy), .Err(err)
    );

    ram_sweep_ctrl #(.DATA_W(8), .ADDR_W(6), .CLR_VAL('h5A)) dut_p (
        .Clk(clk), .Rst_n(p_rst_n), .Clr(p_clr), .Wr(p_wr), .Rd_En(p_rd_en),
        .Addr(p_addr), .Wr_D(p_wr_d), .Rd_D(p_rd_d), .Rd_Vld(p_rd_vld),
        .Busy(p_busy), .Err(p_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input logic [3:0] a, input logic [3:0] d);
        wr = 1'b1; addr = a; wr_d = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic rd_word(input logic [3:0] a);
        rd_en = 1'b1; addr = a;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
        checks++; if (rd_vld !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_strobes got vld=%b err=%b exp=0", rd_vld, err); end
        checks++; if (rd_d !== 4'h0) begin errors++; $display("FAIL reset_rd_d got=%h exp=0", rd_d); end
        rst_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (busy === 1'b1 && n < 100);
        checks++; if (n !== 16) begin errors++; $display("FAIL reset_sweep_len got=%0d exp=16", n); end
        for (int i = 0; i < 16; i++) begin
            rd_word(4'(i));
            checks++;
            if (rd_vld !== 1'b1 || rd_d !== 4'h0) begin
                errors++; $display("FAIL reset_read[%0d] got vld=%b d=%h exp vld=1 d=0", i, rd_vld, rd_d);
            end
        end
        tick();
        checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL reset_vld_drop got=%b exp=0", rd_vld); end
    endtask

    task automatic test_write_read;
        wr_word(4'd3, 4'hA);
        wr_word(4'd15, 4'h5);
        rd_en = 1'b1; addr = 4'd3;
        tick();
        checks++; if (rd_vld !== 1'b1 || rd_d !== 4'hA) begin errors++; $display("FAIL wr_rd_a3 got vld=%b d=%h exp vld=1 d=a", rd_vld, rd_d); end
        addr = 4'd15;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_vld !== 1'b1 || rd_d !== 4'h5) begin errors++; $display("FAIL wr_rd_a15 got vld=%b d=%h exp vld=1 d=5", rd_vld, rd_d); end
        tick();
        checks++; if (rd_vld !== 1'b0 || rd_d !== 4'h5) begin errors++; $display("FAIL wr_rd_hold got vld=%b d=%h exp vld=0 d=5", rd_vld, rd_d); end
    endtask

    task automatic test_write_first;
        wr_word(4'd7, 4'h2);
        wr = 1'b1; rd_en = 1'b1; addr = 4'd7; wr_d = 4'h9;
        tick();
        wr = 1'b0; rd_en = 1'b0;
        checks++; if (rd_vld !== 1'b1 || rd_d !== 4'h9) begin errors++; $display("FAIL write_first got vld=%b d=%h exp vld=1 d=9", rd_vld, rd_d); end
        rd_word(4'd7);
        checks++; if (rd_d !== 4'h9) begin errors++; $display("FAIL write_first_later got=%h exp=9", rd_d); end
    endtask

    task automatic test_clr_collision;
        int n;
        for (int i = 0; i < 16; i++) wr_word(4'(i), 4'hF);
        clr = 1'b1; wr = 1'b1; addr = 4'd2; wr_d = 4'h3;
        tick();
        clr = 1'b0; wr = 1'b0;
        checks++; if (err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL clr_collide got err=%b busy=%b exp 1 1", err, busy); end
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL clr_err_once got=%b exp=0", err); end
        rd_word(4'd2);
        checks++; if (err !== 1'b1 || rd_vld !== 1'b0 || rd_d !== 4'h9) begin
            errors++; $display("FAIL clr_rd_drop got err=%b vld=%b d=%h exp err=1 vld=0 d=9", err, rd_vld, rd_d);
        end
        n = 2;
        while (busy === 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (n !== 16) begin errors++; $display("FAIL clr_sweep_len got=%0d exp=16", n); end
        for (int i = 0; i < 16; i++) begin
            rd_word(4'(i));
            checks++;
            if (rd_vld !== 1'b1 || rd_d !== 4'h0) begin
                errors++; $display("FAIL clr_read[%0d] got vld=%b d=%h exp vld=1 d=0", i, rd_vld, rd_d);
            end
        end
    endtask

    task automatic test_reset_mid_sweep;
        int n;
        wr_word(4'd1, 4'h4);
        wr_word(4'd12, 4'h6);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        tick();
        checks++; if (busy !== 1'b1 || rd_d !== 4'h0) begin errors++; $display("FAIL mid_reset got busy=%b d=%h exp busy=1 d=0", busy, rd_d); end
        rst_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (busy === 1'b1 && n < 100);
        checks++; if (n !== 16) begin errors++; $display("FAIL mid_sweep_len got=%0d exp=16", n); end
        for (int i = 0; i < 16; i++) begin
            rd_word(4'(i));
            checks++;
            if (rd_vld !== 1'b1 || rd_d !== 4'h0) begin
                errors++; $display("FAIL mid_read[%0d] got vld=%b d=%h exp vld=1 d=0", i, rd_vld, rd_d);
            end
        end
    endtask

    task automatic test_param_build;
        int n;
        p_rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (p_busy !== 1'b1 || p_rd_d !== 8'h00) begin errors++; $display("FAIL p_reset got busy=%b d=%h exp busy=1 d=00", p_busy, p_rd_d); end
        p_rst_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (p_busy === 1'b1 && n < 200);
        checks++; if (n !== 64) begin errors++; $display("FAIL p_sweep_len got=%0d exp=64", n); end
        p_rd_en = 1'b1; p_addr = 6'd63;
        tick();
        checks++; if (p_rd_vld !== 1'b1 || p_rd_d !== 8'h5A) begin errors++; $display("FAIL p_read63 got vld=%b d=%h exp vld=1 d=5a", p_rd_vld, p_rd_d); end
        p_addr = 6'd0;
        tick();
        p_rd_en = 1'b0;
        checks++; if (p_rd_d !== 8'h5A) begin errors++; $display("FAIL p_read0 got=%h exp=5a", p_rd_d); end
        p_wr = 1'b1; p_addr = 6'd40; p_wr_d = 8'hC3;
        tick();
        p_wr = 1'b0;
        p_rd_en = 1'b1;
        tick();
        p_rd_en = 1'b0;
        checks++; if (p_rd_vld !== 1'b1 || p_rd_d !== 8'hC3) begin errors++; $display("FAIL p_read40 got vld=%b d=%h exp vld=1 d=c3", p_rd_vld, p_rd_d); end
        checks++; if (p_err !== 1'b0) begin errors++; $display("FAIL p_err got=%b exp=0", p_err); end
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; wr = 1'b0; rd_en = 1'b0; addr = '0; wr_d = '0;
        p_rst_n = 1'b0; p_clr = 1'b0; p_wr = 1'b0; p_rd_en = 1'b0; p_addr = '0; p_wr_d = '0;
        test_reset();
        test_write_read();
        test_write_first();
        test_clr_collision();
        test_reset_mid_sweep();
        test_param_build();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_sweep_ctrl.md
# ram_sweep_ctrl

Parametrised single-port data memory for the processor datapath. It replaces the fixed 16x4 array and adds a registered read with a valid strobe, write-first read-during-write, and a multi-cycle clear sequencer. The sequencer zeroes one word per cycle after reset or on command, and reports its progress through `Busy`. The block sits between the control unit and the register file; the control unit must hold off accesses while `Busy` is high.

## Interface
- `DATA_W`, default 4: word width in bits.
- `ADDR_W`, default 4: address width in bits; depth `DEPTH = 2**ADDR_W`.
- `CLR_VAL`, default 0: value written to every word during a clear sweep (`DATA_W` bits).

Ports:
- `Clk` input, 1 bit: single clock; all state updates on its rising edge.
- `Rst_n` input, 1 bit: reset, synchronous, active-low.
- `Clr` input, 1 bit: starts a clear sweep; sampled only in IDLE.
- `Wr` input, 1 bit: write enable.
- `Rd_En` input, 1 bit: read request.
- `Addr` input, `ADDR_W` bits: address for both read and write.
- `Wr_D` input, `DATA_W` bits: write data.
- `Rd_D` output, `DATA_W` bits: registered read data.
- `Rd_Vld` output, 1 bit: one-cycle pulse, high when `Rd_D` carries the data for the previous request.
- `Busy` output, 1 bit: high while a clear sweep is in progress (state CLEAR).
- `Err` output, 1 bit: one-cycle pulse flagging an access request that was dropped.

## Operation
- The FSM has two states: CLEAR and IDLE. An internal sweep counter `cnt` is `ADDR_W` bits wide.
- **Reset.** At any edge where `Rst_n`=0 the block forces:
  - state = CLEAR, `cnt` = 0;
  - `Rd_D` = 0, `Rd_Vld` = 0, `Err` = 0, `Busy` = 1.
  - No array write happens on a reset edge.
  - Reset asserted mid-sweep restarts the sweep from address 0.
- **CLEAR.** Each edge with `Rst_n`=1 writes `mem[cnt] <= CLR_VAL` and increments `cnt`.
  - On the edge that writes address `DEPTH-1`, the FSM moves to IDLE, `cnt` wraps to 0, and `Busy` drops.
  - `Wr`, `Rd_En` and `Clr` are ignored in CLEAR. If `Wr` or `Rd_En` is high on such an edge, `Err` pulses for one cycle; the array and `Rd_D` are untouched and `Rd_Vld` stays 0.
- **IDLE, priority order:**
  1. `Clr`=1: go to CLEAR with `cnt`=0 and set `Busy`. A `Wr` or `Rd_En` on the same edge is dropped and `Err` pulses.
  2. Otherwise, `Wr`=1 writes `mem[Addr] <= Wr_D`.
  3. `Rd_En`=1 (may coincide with `Wr`) sets `Rd_D <= mem[Addr]` and `Rd_Vld <= 1`.
     - If `Wr` is also high, `Addr` is shared, so `Rd_D <= Wr_D` (write-first).
- `Rd_D` holds its last value when no read completes. `Rd_Vld` and `Err` are 0 on every edge that does not set them.
- Array contents are not reset directly; they are defined only after a completed sweep.
- `CLR_VAL` is truncated or zero-extended to `DATA_W` bits.

## Timing
- **Read latency:** 1 cycle. A request sampled at edge N gives `Rd_D`/`Rd_Vld` valid after edge N, i.e. during cycle N+1.
- **Back-to-back reads:** one per cycle; `Rd_Vld` stays high continuously.
- **Write:** takes effect at the sampling edge. A read of the same address on the next edge returns the new data.
- **Sweep duration:** exactly `DEPTH` edges with `Rst_n`=1.
  - After `Rst_n` rises before edge 0, `Busy` is low from edge `DEPTH-1` onward.
  - The first accepted access is at edge `DEPTH`.
- **`Clr` in IDLE at edge N:** `Busy` is high after N; the sweep writes addresses 0..DEPTH-1 on edges N+1..N+DEPTH; `Busy` is low after edge N+DEPTH.
- **Outputs:** all are registered; there is no combinational input-to-output path.

## Test plan
- **Reset sweep.** Default params. Hold `Rst_n`=0 for 3 cycles, then release. Required: `Busy`=1 for 16 edges, then 0. Reading addresses 0..15 returns 0x0 with `Rd_Vld` one cycle after each request.
- **Write/read.** Write 0xA to address 3 and 0x5 to address 15, then read 3 and 15 back-to-back. Required: `Rd_D`=0xA, then 0x5, with `Rd_Vld` high for 2 consecutive cycles.
- **Write-first.** Address 7 holds 0x2. Assert `Wr`=1, `Rd_En`=1, `Addr`=7, `Wr_D`=0x9 on the same edge. Required: `Rd_D`=0x9 next cycle; a later read of 7 also returns 0x9.
- **Clr with collision.** Fill the array with 0xF. Assert `Clr`=1 together with `Wr`=1, `Addr`=2, `Wr_D`=0x3. Required: `Err` pulses once and `Busy` is high for 16 cycles. Issue `Rd_En` during the sweep: `Err` pulses and `Rd_Vld` stays 0. After the sweep, all reads return 0x0.
- **Reset mid-sweep.** Assert `Rst_n`=0 at sweep cycle 9, release after 1 cycle. Required: `Busy` is high for a full 16 further edges, then all addresses read 0.
- **Parametrised build.** `DATA_W`=8, `ADDR_W`=6, `CLR_VAL`=0x5A. Required: `Busy` lasts 64 edges after reset; address 63 reads 0x5A; write/read of 0xC3 at address 40 round-trips.
